// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: fixed-latency loads, forwarding write queue
module dmem_responder #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int MEM_AW   = 10,
    parameter int LOAD_LAT = 2,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_req_i,
    input  logic [ADDR_LEN-1:0] load_addr_i,
    input  logic                store_we_i,
    input  logic [ADDR_LEN-1:0] store_addr_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    input  logic                drain_stall_i,
    output logic                busy_o,
    output logic                complete_o,
    output logic [DATA_LEN-1:0] load_data_o,
    output logic                store_full_o,
    output logic                wq_empty_o,
    output logic                overflow_o
);
    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [MEM_AW-1:0]   ld_idx;
    logic [DATA_LEN-1:0] mem [2**MEM_AW];
    logic [MEM_AW-1:0]   wq_addr [WQ_DEPTH];
    logic [DATA_LEN-1:0] wq_data [WQ_DEPTH];
    logic [PW-1:0]       head, tail, slot;
    logic [PW:0]         count, count_nxt;
    logic [DATA_LEN-1:0] fwd_data;
    logic                respond, enq, drain;

    assign respond = (state == S_WAIT) && (cnt == '0);
    assign enq     = store_we_i && (count != (PW+1)'(WQ_DEPTH));
    // The array has one port: a responding load owns it, so drain yields.
    assign drain   = (count != '0) && !drain_stall_i && !respond;

    always_comb begin
        count_nxt = count;
        if (enq && !drain)
            count_nxt = count + 1'b1;
        else if (!enq && drain)
            count_nxt = count - 1'b1;
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_data = mem[ld_idx];
        slot     = '0;
        for (int k = 0; k < WQ_DEPTH; k++) begin
            slot = head + PW'(k);
            if (((PW+1)'(k) < count) && (wq_addr[slot] == ld_idx))
                fwd_data = wq_data[slot];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ld_idx       <= '0;
            busy_o       <= 1'b0;
            complete_o   <= 1'b0;
            load_data_o  <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            store_full_o <= 1'b0;
            wq_empty_o   <= 1'b1;
            overflow_o   <= 1'b0;
        end else begin
            complete_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_req_i) begin
                        ld_idx <= load_addr_i[MEM_AW+1:2];
                        cnt    <= CW'(LOAD_LAT - 1);
                        busy_o <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        load_data_o <= fwd_data;
                        complete_o  <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enq) begin
                wq_addr[tail] <= store_addr_i[MEM_AW+1:2];
                wq_data[tail] <= store_data_i;
                tail          <= tail + 1'b1;
            end else if (store_we_i) begin
                overflow_o <= 1'b1;
            end
            if (drain)
                head <= head + 1'b1;

            count        <= count_nxt;
            store_full_o <= (count_nxt == (PW+1)'(WQ_DEPTH));
            wq_empty_o   <= (count_nxt == '0);
        end
    end

    // Array is not reset; a reset edge also suppresses any pending drain.
    always_ff @(posedge clk_i) begin
        if (reset_i && drain)
            mem[wq_addr[head]] <= wq_data[head];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        load_req_i = 1'b0;
    logic [31:0] load_addr_i = '0;
    logic        store_we_i = 1'b0;
    logic [31:0] store_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        drain_stall_i = 1'b0;
    logic        busy_o, complete_o, store_full_o, wq_empty_o, overflow_o;
    logic [31:0] load_data_o;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_LEN(32), .ADDR_LEN(32), .MEM_AW(10), .LOAD_LAT(2), .WQ_DEPTH(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .load_req_i(load_req_i), .load_addr_i(load_addr_i),
        .store_we_i(store_we_i), .store_addr_i(store_addr_i), .store_data_i(store_data_i),
        .drain_stall_i(drain_stall_i),
        .busy_o(busy_o), .complete_o(complete_o), .load_data_o(load_data_o),
        .store_full_o(store_full_o), .wq_empty_o(wq_empty_o), .overflow_o(overflow_o)
    );

    int          npass = 0;
    int          ntotal = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model[int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3ff);
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        return model.exists(widx(a)) ? model[widx(a)] : 32'hxxxx_xxxx;
    endfunction

    // Every completion is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (complete_o) begin
            if (exp_q.size() == 0) check("stray_complete", 32'd1, 32'd0);
            else check("load_data", load_data_o, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit upd);
        store_we_i = 1'b1; store_addr_i = a; store_data_i = d;
        step();
        store_we_i = 1'b0;
        if (upd) model[widx(a)] = d;
    endtask

    task automatic do_load(input logic [31:0] a);
        int guard = 0;
        load_req_i = 1'b1; load_addr_i = a;
        while (busy_o && guard < 20) begin step(); guard++; end
        if (guard >= 20) check("accept_timeout", 32'd1, 32'd0);
        exp_q.push_back(expect_word(a));
        step();
        load_req_i = 1'b0;
    endtask

    task automatic wait_complete();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin step(); guard++; end
        if (guard >= 20) check("complete_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (!wq_empty_o && guard < 20) begin step(); guard++; end
        if (guard >= 20) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int cyc;
        int last;
        int ncomp;
        logic [31:0] a;

        // 1: reset state
        step(); step();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_complete", 32'(complete_o), 32'd0);
        check("rst_data", load_data_o, 32'd0);
        check("rst_full", 32'(store_full_o), 32'd0);
        check("rst_empty", 32'(wq_empty_o), 32'd1);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        reset_i = 1'b1;
        step();

        // 2: store, drain, then exact load timing
        do_store(32'h100, 32'hDEADBEEF, 1'b1);
        wait_empty();
        load_req_i = 1'b1; load_addr_i = 32'h100;
        exp_q.push_back(expect_word(32'h100));
        check("t2_busy_n", 32'(busy_o), 32'd0);
        step(); load_req_i = 1'b0;
        check("t2_busy_n1", 32'(busy_o), 32'd1);
        check("t2_cmp_n1", 32'(complete_o), 32'd0);
        step();
        check("t2_busy_n2", 32'(busy_o), 32'd1);
        check("t2_cmp_n2", 32'(complete_o), 32'd0);
        step();
        check("t2_busy_n3", 32'(busy_o), 32'd0);
        check("t2_cmp_n3", 32'(complete_o), 32'd1);
        step();
        check("t2_cmp_n4", 32'(complete_o), 32'd0);
        check("t2_data_held", load_data_o, 32'hDEADBEEF);

        // 3: youngest pending store forwards while the drain is stalled
        drain_stall_i = 1'b1;
        do_store(32'h40, 32'h1, 1'b1);
        do_store(32'h40, 32'h2, 1'b1);
        do_load(32'h40);
        wait_complete();
        check("t3_not_drained", 32'(wq_empty_o), 32'd0);
        drain_stall_i = 1'b0;
        wait_empty();
        do_load(32'h40);
        wait_complete();

        // 4: fill, overflow, drain count, dropped store never lands
        do_store(32'h10, 32'h55, 1'b1);
        wait_empty();
        drain_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'hA0 + 32'(i), 1'b1);
        check("t4_full", 32'(store_full_o), 32'd1);
        check("t4_no_ovf_yet", 32'(overflow_o), 32'd0);
        do_store(32'h10, 32'h99, 1'b0);
        check("t4_ovf", 32'(overflow_o), 32'd1);
        drain_stall_i = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (!wq_empty_o && cyc < 20);
        check("t4_drain_cycles", 32'(cyc), 32'd4);
        check("t4_not_full", 32'(store_full_o), 32'd0);
        do_load(32'h10);
        do_load(32'hC);
        wait_complete();

        // 5: reset mid-load aborts the load and discards queued stores
        do_store(32'h200, 32'h11, 1'b1);
        wait_empty();
        drain_stall_i = 1'b1;
        do_store(32'h200, 32'h22, 1'b1);
        load_req_i = 1'b1; load_addr_i = 32'h200;
        step();
        load_req_i = 1'b0;
        reset_i = 1'b0;
        exp_q.delete();
        step();
        reset_i = 1'b1;
        drain_stall_i = 1'b0;
        model[widx(32'h200)] = 32'h11;
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_empty", 32'(wq_empty_o), 32'd1);
        check("t5_ovf_clr", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 5; i++) step();
        do_load(32'h200);
        wait_complete();

        // 6: back-to-back loads with the request held high
        a = 32'h100; last = -1; ncomp = 0;
        load_req_i = 1'b1; load_addr_i = a;
        for (int i = 0; i < 12; i++) begin
            bit acc;
            acc = !busy_o;
            if (acc) exp_q.push_back(expect_word(a));
            if (complete_o) begin
                if (last >= 0) check("t6_spacing", 32'(i - last), 32'd3);
                last = i;
                ncomp++;
            end
            step();
            if (acc) begin
                a = (a == 32'h100) ? 32'h40 : 32'h100;
                load_addr_i = a;
            end
        end
        load_req_i = 1'b0;
        check("t6_ncomp", 32'(ncomp), 32'd3);
        wait_complete();
        step(); step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
